// File: rtl/bit_serial_pkg.sv
// Shared types for the bit-serial core.
// Opcodes, FSM states and the counter width helper.
package bit_serial_pkg;

    typedef enum logic [2:0] {
        OP_LDSW  = 3'd0,
        OP_LDACC = 3'd1,
        OP_ADD   = 3'd2,
        OP_SUB   = 3'd3,
        OP_AND   = 3'd4,
        OP_OR    = 3'd5,
        OP_XOR   = 3'd6,
        OP_ST    = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/bit_serial_core_if.sv
// Instruction/handshake bundle between front end and the core.
// Master drives the request side, slave is the core.
interface bit_serial_core_if #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
);
    localparam int AW = $clog2(NREGS);

    logic              i_start;
    logic [2+AW:0]     i_data_instruction;
    logic [WIDTH-1:0]  i_data_switch;
    logic              o_busy;
    logic              o_con_pcincr;
    logic              o_flag_carry;
    logic              o_flag_zero;
    logic [WIDTH-1:0]  o_data_display;

    modport master (
        output i_start,
        output i_data_instruction,
        output i_data_switch,
        input  o_busy,
        input  o_con_pcincr,
        input  o_flag_carry,
        input  o_flag_zero,
        input  o_data_display
    );

    modport slave (
        input  i_start,
        input  i_data_instruction,
        input  i_data_switch,
        output o_busy,
        output o_con_pcincr,
        output o_flag_carry,
        output o_flag_zero,
        output o_data_display
    );

endinterface

// File: rtl/bit_serial_alu.sv
// One-bit ALU slice: full adder with optional b inversion,
// plus bitwise logic and operand pass-through.
module bit_serial_alu
    import bit_serial_pkg::*;
(
    input  logic    a_i,
    input  logic    b_i,
    input  logic    cin_i,
    input  opcode_e op_i,
    output logic    res_o,
    output logic    cout_o
);

    logic bx;
    logic sum;
    logic carry;

    assign bx    = (op_i == OP_SUB) ? ~b_i : b_i;
    assign sum   = a_i ^ bx ^ cin_i;
    assign carry = (a_i & bx) | (cin_i & (a_i ^ bx));

    // Select the result bit; carry-out only for arithmetic
    always_comb begin
        res_o  = 1'b0;
        cout_o = 1'b0;
        unique case (op_i)
            OP_ADD, OP_SUB: begin
                res_o  = sum;
                cout_o = carry;
            end
            OP_AND:            res_o = a_i & b_i;
            OP_OR:             res_o = a_i | b_i;
            OP_XOR:            res_o = a_i ^ b_i;
            OP_LDSW, OP_LDACC: res_o = b_i;
            OP_ST:             res_o = a_i;
            default:           res_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/bit_serial_core.sv
// Bit-serial processor datapath: ACC and GPRs rotate LSB-first
// through a 1-bit ALU, one instruction per start handshake.
module bit_serial_core
    import bit_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    bit_serial_core_if.slave    bus
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    opcode_e          op_q;
    logic [AW-1:0]    addr_q;
    logic [WIDTH-1:0] sw_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] gpr_q [NREGS];
    logic             carry_q;
    logic             zacc_q;
    logic             busy_q;
    logic             pc_q;
    logic             fc_q;
    logic             fz_q;
    logic [WIDTH-1:0] disp_q;

    logic [WIDTH-1:0] gpr_sel;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] gpr_d;
    logic             wr_gpr;
    logic             b_bit;
    logic             res;
    logic             cout;

    assign gpr_sel = gpr_q[addr_q];
    assign wr_gpr  = (op_q == OP_LDSW) || (op_q == OP_ST);
    assign b_bit   = (op_q == OP_LDSW) ? sw_q[cnt_q] : gpr_sel[0];

    bit_serial_alu u_alu (
        .a_i    (acc_q[0]),
        .b_i    (b_bit),
        .cin_i  (carry_q),
        .op_i   (op_q),
        .res_o  (res),
        .cout_o (cout)
    );

    // Next rotation of ACC and the addressed GPR; the written one takes res
    always_comb begin
        acc_d = {acc_q[0], acc_q[WIDTH-1:1]};
        gpr_d = {gpr_sel[0], gpr_sel[WIDTH-1:1]};
        if (wr_gpr) begin
            gpr_d = {res, gpr_sel[WIDTH-1:1]};
        end else begin
            acc_d = {res, acc_q[WIDTH-1:1]};
        end
    end

    // Control FSM, bit counter, register file and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_LDSW;
            addr_q  <= '0;
            sw_q    <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            busy_q  <= 1'b0;
            pc_q    <= 1'b0;
            fc_q    <= 1'b0;
            fz_q    <= 1'b0;
            disp_q  <= '0;
            for (int i = 0; i < NREGS; i++) begin
                gpr_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    pc_q <= 1'b0;
                    if (bus.i_start) begin
                        op_q    <= opcode_e'(bus.i_data_instruction[2+AW:AW]);
                        addr_q  <= bus.i_data_instruction[AW-1:0];
                        sw_q    <= bus.i_data_switch;
                        carry_q <= (bus.i_data_instruction[2+AW:AW] == OP_SUB);
                        zacc_q  <= 1'b1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    acc_q          <= acc_d;
                    gpr_q[addr_q]  <= gpr_d;
                    carry_q        <= cout;
                    zacc_q         <= zacc_q & ~res;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        pc_q    <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    pc_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    if (wr_gpr) begin
                        disp_q <= gpr_sel;
                    end else begin
                        disp_q <= acc_q;
                        fz_q   <= zacc_q;
                        fc_q   <= (op_q == OP_ADD || op_q == OP_SUB) ? carry_q : 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_busy         = busy_q;
    assign bus.o_con_pcincr   = pc_q;
    assign bus.o_flag_carry   = fc_q;
    assign bus.o_flag_zero    = fz_q;
    assign bus.o_data_display = disp_q;

endmodule

// File: tb/tb_bit_serial_core.sv
// Bench for bit_serial_core: directed plan plus random ops
// checked against an arithmetic model of the instruction set.
module tb_bit_serial_core;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bit_serial_core_if #(.WIDTH(W), .NREGS(N)) bus ();
    bit_serial_core #(.WIDTH(W), .NREGS(N)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    bit_serial_core_if #(.WIDTH(16), .NREGS(8)) bus16 ();
    bit_serial_core #(.WIDTH(16), .NREGS(8)) dut16 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus16)
    );

    logic [7:0] m_r [N];
    logic [7:0] m_acc;
    logic [7:0] m_disp;
    logic       m_c;
    logic       m_z;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_r[i] = '0;
        m_acc = '0; m_disp = '0; m_c = 0; m_z = 0;
    endtask

    task automatic model(input int op, input int a, input logic [7:0] sw);
        logic [8:0] s;
        case (op)
            0: begin m_r[a] = sw; m_disp = sw; end
            7: begin m_r[a] = m_acc; m_disp = m_acc; end
            default: begin
                m_c = 0;
                case (op)
                    1: m_acc = m_r[a];
                    2: begin s = m_acc + m_r[a]; m_acc = s[7:0]; m_c = s[8]; end
                    3: begin m_c = (m_acc >= m_r[a]); m_acc = m_acc - m_r[a]; end
                    4: m_acc = m_acc & m_r[a];
                    5: m_acc = m_acc | m_r[a];
                    default: m_acc = m_acc ^ m_r[a];
                endcase
                m_z = (m_acc == 0);
                m_disp = m_acc;
            end
        endcase
    endtask

    task automatic check_out(input string tag);
        check({tag, "_disp"}, bus.o_data_display, m_disp);
        check({tag, "_carry"}, bus.o_flag_carry, m_c);
        check({tag, "_zero"}, bus.o_flag_zero, m_z);
    endtask

    // Issue one op at a negedge; ends at a negedge with the core idle
    task automatic run_op(input int op, input int a, input logic [7:0] sw);
        int bc, pcn, pca;
        bc = 0; pcn = 0; pca = 0;
        bus.i_data_instruction = {3'(op), 2'(a)};
        bus.i_data_switch = sw;
        bus.i_start = 1'b1;
        for (int k = 1; k <= W + 3; k++) begin
            @(negedge clk);
            if (k == 1) bus.i_start = 1'b0;
            bc += int'(bus.o_busy);
            if (bus.o_con_pcincr) begin pcn++; pca = k; end
        end
        model(op, a, sw);
        check("busy_len", bc, W + 1);
        check("pc_cnt", pcn, 1);
        check("pc_pos", pca, W + 1);
        check_out("op");
    endtask

    task automatic run16(input int op, input int a, input logic [15:0] sw, output int bc);
        bc = 0;
        bus16.i_data_instruction = {3'(op), 3'(a)};
        bus16.i_data_switch = sw;
        bus16.i_start = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (k == 1) bus16.i_start = 1'b0;
            bc += int'(bus16.o_busy);
        end
    endtask

    initial begin
        int pcn, last, bc, seen;
        bus.i_start = 0; bus.i_data_instruction = '0; bus.i_data_switch = '0;
        bus16.i_start = 0; bus16.i_data_instruction = '0; bus16.i_data_switch = '0;
        model_reset();
        rst = 1'b1;
        bus.i_start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.o_busy, 0);
        check("rst_pc", bus.o_con_pcincr, 0);
        rst = 1'b0;
        bus.i_start = 1'b0;
        check_out("rst");

        run_op(0, 1, 8'hA5);
        check("t1_disp", bus.o_data_display, 8'hA5);

        run_op(0, 0, 8'hFF); run_op(0, 1, 8'h01);
        run_op(1, 0, 0); run_op(2, 1, 0);
        check("t2_disp", bus.o_data_display, 0);
        check("t2_carry", bus.o_flag_carry, 1);

        run_op(0, 2, 8'h07); run_op(0, 3, 8'h05);
        run_op(1, 3, 0); run_op(3, 2, 0);
        check("t3_disp", bus.o_data_display, 8'hFE);
        run_op(1, 3, 0); run_op(3, 3, 0);
        check("t3_zero", bus.o_flag_zero, 1);

        run_op(0, 0, 8'hF0); run_op(0, 1, 8'h3C);
        run_op(1, 0, 0); run_op(4, 1, 0);
        run_op(1, 0, 0); run_op(5, 1, 0);
        run_op(1, 0, 0); run_op(6, 1, 0);
        check("t4_xor", bus.o_data_display, 8'hCC);
        run_op(1, 1, 0);

        run_op(0, 2, 8'h5A); run_op(1, 2, 0);
        run_op(7, 3, 0); run_op(0, 2, 8'h00); run_op(1, 3, 0);

        // Held start: ADD R1 re-fires on every return to IDLE
        bus.i_data_instruction = {3'd2, 2'd1};
        bus.i_start = 1'b1;
        pcn = 0; last = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bus.o_con_pcincr) begin
                if (pcn > 0) check("pc_spacing", k - last, W + 2);
                last = k; pcn++;
            end
        end
        bus.i_start = 1'b0;
        check("held_count", pcn, 3);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) model(2, 1, 0);
        check_out("held");

        // Start pulse landing only in DONE is dropped
        bus.i_data_instruction = {3'd0, 2'd2};
        bus.i_data_switch = 8'h66;
        bus.i_start = 1'b1;
        seen = 0;
        for (int k = 1; k <= W + 3 && seen == 0; k++) begin
            @(negedge clk);
            bus.i_start = 1'b0;
            if (bus.o_con_pcincr) seen = 1;
        end
        check("done_seen", seen, 1);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        bc = 0;
        repeat (W + 3) begin
            @(negedge clk);
            bc += int'(bus.o_busy);
        end
        check("done_ignored", bc, 0);
        model(0, 2, 8'h66);
        check_out("done");

        for (int i = 0; i < 150; i++) begin
            run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 8'($urandom));
        end

        // Reset on EXEC cycle 4 of an ADD
        run_op(0, 0, 8'h33); run_op(1, 0, 0);
        bus.i_data_instruction = {3'd2, 2'd0};
        bus.i_start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus.i_start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("mid_busy", bus.o_busy, 0);
        check_out("mid");
        pcn = 0;
        repeat (W + 2) begin
            @(negedge clk);
            pcn += int'(bus.o_con_pcincr);
        end
        check("mid_nopc", pcn, 0);
        run_op(7, 2, 0);
        for (int i = 0; i < N; i++) run_op(1, i, 0);

        // 16-bit, 8-register build
        run16(0, 0, 16'hFFFF, bc);
        run16(0, 5, 16'h0001, bc);
        check("w16_ldsw_busy", bc, 17);
        run16(1, 0, 0, bc);
        check("w16_ldacc", bus16.o_data_display, 16'hFFFF);
        run16(2, 5, 0, bc);
        check("w16_busy", bc, 17);
        check("w16_disp", bus16.o_data_display, 0);
        check("w16_carry", bus16.o_flag_carry, 1);
        check("w16_zero", bus16.o_flag_zero, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
